mem_port_arbiter: RTL

//  Shares the single cache_ctrl user port (i_rd_en/i_wr_en/i_addr/i_data/i_mask/o_data/o_busy)

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single cache_ctrl user port.
// Issues one-cycle enable pulses, holds address/data/mask until m_busy drops, then acks the owner.
`timescale 1ns / 1ps
module mem_port_arbiter #(
    parameter int unsigned FIXED_PRIO  = 0,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        c0_rd_en,
    input  logic        c0_wr_en,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic [3:0]  c0_mask,
    output logic        c0_ack,
    output logic [31:0] c0_rdata,
    input  logic        c1_rd_en,
    input  logic        c1_wr_en,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c1_wdata,
    input  logic [3:0]  c1_mask,
    output logic        c1_ack,
    output logic [31:0] c1_rdata,
    output logic        m_rd_en,
    output logic        m_wr_en,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_mask,
    input  logic [31:0] m_rdata,
    input  logic        m_busy,
    output logic        o_grant,
    output logic        o_timeout,
    output logic [1:0]  o_state
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mask_q, mask_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              timeout_q, timeout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              req0, req1;
    logic              done;
    logic              ack0, ack1;
    logic              elig0, elig1;
    logic              winner;
    logic              launch;
    logic              sel_wr;
    logic [31:0]       sel_addr, sel_wdata;
    logic [3:0]        sel_mask;

    assign req0 = c0_rd_en | c0_wr_en;
    assign req1 = c1_rd_en | c1_wr_en;

    // Completion cycle: first busy-low cycle after the issue cycle.
    assign done = (state_q == StWait) && !m_busy;
    assign ack0 = done && !grant_q;
    assign ack1 = done && grant_q;

    // The port being acked this cycle still holds its old request; it must not win again.
    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;

    always_comb begin
        winner = 1'b0;
        if (elig0 && elig1) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            winner = elig1;
        end
    end

    assign launch = !m_busy && (state_q != StIssue) && (elig0 || elig1);

    // A port raising both enables is treated as a write.
    assign sel_wr    = winner ? c1_wr_en : c0_wr_en;
    assign sel_addr  = winner ? c1_addr  : c0_addr;
    assign sel_wdata = winner ? c1_wdata : c0_wdata;
    assign sel_mask  = winner ? c1_mask  : c0_mask;

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        grant_d   = grant_q;
        last_d    = last_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (m_busy) begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q + CntW'(1) == CntMax) begin
                            timeout_d = 1'b1;
                        end
                    end
                end else if (launch) begin
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch && (state_q != StIssue)) begin
            rd_en_d = ~sel_wr;
            wr_en_d = sel_wr;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            mask_d  = sel_mask;
            grant_d = winner;
            last_d  = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q   <= StIdle;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign c0_ack    = ack0;
    assign c1_ack    = ack1;
    assign c0_rdata  = m_rdata;
    assign c1_rdata  = m_rdata;
    assign m_rd_en   = rd_en_q;
    assign m_wr_en   = wr_en_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_mask    = mask_q;
    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;
    assign o_state   = state_q;

endmodule
